// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch controller: FSM states, the
// decode-facing slot layout and the reset instruction.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    localparam logic [FETCH_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] instr;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_slot_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Decode-facing output register backed by a single-entry skid, so one response
// that lands while decode is stalled is held rather than lost.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  fetch_slot_t slot_in,
    input  logic        stall,
    input  logic        flush,
    output fetch_slot_t slot_out,
    output logic        valid,
    output logic        full
);

    fetch_slot_t out_q;
    fetch_slot_t skid_q;
    logic        out_v;
    logic        skid_v;
    logic        free;

    // The output slot can take new data when empty or being consumed this cycle.
    assign free = !out_v || !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= {NOP_INSTR, {FETCH_XLEN{1'b0}}};
            skid_q <= {NOP_INSTR, {FETCH_XLEN{1'b0}}};
            out_v  <= 1'b0;
            skid_v <= 1'b0;
        end else if (flush) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
        end else if (free) begin
            if (skid_v) begin
                out_q  <= skid_q;
                out_v  <= 1'b1;
                skid_v <= load;
                if (load) begin
                    skid_q <= slot_in;
                end
            end else if (load) begin
                out_q <= slot_in;
                out_v <= 1'b1;
            end else begin
                out_v <= 1'b0;
            end
        end else if (load && !skid_v) begin
            skid_q <= slot_in;
            skid_v <= 1'b1;
        end
    end

    assign slot_out = out_q;
    assign valid    = out_v;
    assign full     = skid_v;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, keeps one instruction-memory request in
// flight at a time and discards any response made stale by a redirect.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                         DATA_WIDTH    = 32,
    parameter int                         ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic                     instr_valid,
    output logic [DATA_WIDTH-1:0]    instr_o,
    output logic [ADDRESS_WIDTH-1:0] pc_o,
    output logic [ADDRESS_WIDTH-1:0] pcplus4_o,
    output fetch_state_e             fsm_state,
    output logic                     skid_full
);

    // Handshakes: a request transfers on a cycle with imem_req && imem_gnt;
    // imem_rvalid returns exactly one response per transfer, in order, on a
    // later cycle; decode takes instr_o on any cycle with instr_valid && !stall.

    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(4);

    fetch_state_e              state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDRESS_WIDTH-1:0]  pending_pc_q, pending_pc_d;
    logic [ADDRESS_WIDTH-1:0]  redirect_target;
    logic                      load;
    fetch_slot_t               slot_in;
    fetch_slot_t               slot_out;

    assign redirect_target = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = pending_pc_q;
        imem_req     = 1'b0;
        load         = 1'b0;
        case (state_q)
            S_REQ: begin
                imem_req = !skid_full && !rst;
                if (redirect) begin
                    fetch_pc_d = redirect_target;
                    // A grant in the redirect cycle commits a request we no longer want.
                    if (imem_req && imem_gnt) begin
                        state_d = S_DROP;
                    end
                end else if (imem_req && imem_gnt) begin
                    pending_pc_d = fetch_pc_q;
                    fetch_pc_d   = fetch_pc_q + PC_STEP;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    fetch_pc_d = redirect_target;
                    state_d    = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    load    = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    fetch_pc_d = redirect_target;
                end
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
        end
    end

    assign slot_in = {imem_rdata, pending_pc_q};

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .slot_in  (slot_in),
        .stall    (stall),
        .flush    (redirect),
        .slot_out (slot_out),
        .valid    (instr_valid),
        .full     (skid_full)
    );

    assign imem_addr = fetch_pc_q;
    assign instr_o   = slot_out.instr;
    assign pc_o      = slot_out.pc;
    assign pcplus4_o = slot_out.pc + PC_STEP;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a behavioural memory plus a queue-based
// model of delivered instructions, directed scenarios and a random soak.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic               clk;
    logic               rst;
    logic               stall;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic               imem_req;
    logic [31:0]        imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [31:0]        imem_rdata;
    logic               instr_valid;
    logic [31:0]        instr_o;
    logic [31:0]        pc_o;
    logic [31:0]        pcplus4_o;
    fetch_state_e       fsm_state;
    logic               skid_full;

    fetch_ctrl #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_o     (instr_o),
        .pc_o        (pc_o),
        .pcplus4_o   (pcplus4_o),
        .fsm_state   (fsm_state),
        .skid_full   (skid_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: instructions delivered to decode but not yet consumed, oldest first.
    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_pc_q[$];
    logic        m_out;
    logic        m_stale;
    logic [31:0] m_out_pc;
    logic [31:0] m_fetch_pc;

    // Memory: single outstanding request, response due k cycles after grant.
    logic        mem_busy;
    int          mem_due;
    logic [31:0] mem_addr;
    int          k_min = 1;
    int          k_max = 1;
    int          gnt_pct = 100;
    logic        last_grant;
    logic [31:0] last_grant_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic model_reset();
        exp_instr_q.delete();
        exp_pc_q.delete();
        m_out      = 1'b0;
        m_stale    = 1'b0;
        m_out_pc   = 32'h0;
        m_fetch_pc = 32'h0;
        mem_busy   = 1'b0;
    endtask

    task automatic cycle();
        logic exp_req;
        logic granted;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (!rst && mem_busy && cyc >= mem_due) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_addr);
        end
        imem_gnt = ($urandom_range(1, 100) <= gnt_pct);
        #1;
        exp_req = !rst && !m_out && (exp_pc_q.size() < 2);
        checks++;
        if (imem_req !== exp_req) begin
            failures++;
            $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, imem_req, exp_req);
        end
        if (exp_req) begin
            checks++;
            if (imem_addr !== m_fetch_pc) begin
                failures++;
                $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_fetch_pc);
            end
        end
        granted    = exp_req && imem_gnt;
        last_grant = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            if (imem_rvalid) mem_busy = 1'b0;
            if (imem_req && imem_gnt) begin
                mem_busy        = 1'b1;
                mem_addr        = imem_addr;
                mem_due         = cyc + $urandom_range(k_min, k_max);
                last_grant      = 1'b1;
                last_grant_addr = imem_addr;
            end
            if (exp_pc_q.size() > 0 && !stall) begin
                void'(exp_instr_q.pop_front());
                void'(exp_pc_q.pop_front());
            end
            if (redirect) begin
                exp_instr_q.delete();
                exp_pc_q.delete();
                m_fetch_pc = {redirect_pc[31:2], 2'b00};
                if (imem_rvalid) m_out = 1'b0;
                if (granted) begin
                    m_out   = 1'b1;
                    m_stale = 1'b1;
                end else if (m_out) begin
                    m_stale = 1'b1;
                end
            end else begin
                if (imem_rvalid) begin
                    if (m_out && !m_stale) begin
                        exp_instr_q.push_back(imem_rdata);
                        exp_pc_q.push_back(m_out_pc);
                    end
                    m_out = 1'b0;
                end
                if (granted) begin
                    m_out      = 1'b1;
                    m_stale    = 1'b0;
                    m_out_pc   = m_fetch_pc;
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        if (instr_valid !== (exp_pc_q.size() > 0)) begin
            failures++;
            $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, instr_valid, exp_pc_q.size() > 0);
        end
        checks++;
        if (skid_full !== (exp_pc_q.size() == 2)) begin
            failures++;
            $display("FAIL skid_full cyc=%0d got=%b exp=%b", cyc, skid_full, exp_pc_q.size() == 2);
        end
        if (exp_pc_q.size() > 0) begin
            checks++;
            if (instr_o !== exp_instr_q[0] || pc_o !== exp_pc_q[0] || pcplus4_o !== exp_pc_q[0] + 32'd4) begin
                failures++;
                $display("FAIL slot cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, instr_o, pc_o, pcplus4_o,
                         exp_instr_q[0], exp_pc_q[0], exp_pc_q[0] + 32'd4);
            end
        end
    endtask

    task automatic run_until_grant(input logic [31:0] addr, input logic any, input int bound);
        logic found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            cycle();
            if (last_grant && (any || last_grant_addr == addr)) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL grant_timeout got=none exp=%h", addr);
        end
    endtask

    task automatic run_until_valid(input int bound);
        logic found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            cycle();
            if (instr_valid === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL valid_timeout got=0 exp=1");
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (instr_valid !== 1'b0 || instr_o !== NOP_INSTR || pc_o !== 32'h0 || pcplus4_o !== 32'h4) begin
            failures++;
            $display("FAIL %s outputs got=%b/%h/%h/%h exp=0/00000013/0/4", tag, instr_valid, instr_o, pc_o, pcplus4_o);
        end
        checks++;
        if (imem_req !== 1'b0 || fsm_state !== S_REQ || skid_full !== 1'b0) begin
            failures++;
            $display("FAIL %s state got=%b/%0d/%b exp=0/%0d/0", tag, imem_req, fsm_state, skid_full, S_REQ);
        end
    endtask

    task automatic test_reset();
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        k_min = 1; k_max = 1; gnt_pct = 100;
        model_reset();
        rst = 1'b1;
        cycle();
        cycle();
        check_reset_values("reset");
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] grants[$];
        logic [31:0] pcs[$];
        logic [5:0]  pat = '0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (last_grant) grants.push_back(last_grant_addr);
            if (instr_valid) pcs.push_back(pc_o);
            pat = {pat[4:0], instr_valid};
        end
        checks++;
        if (grants.size() != 3 || grants[0] !== 32'h0 || grants[1] !== 32'h4 || grants[2] !== 32'h8) begin
            failures++;
            $display("FAIL basic_addrs got_n=%0d exp=0,4,8", grants.size());
        end
        checks++;
        if (pcs.size() != 3 || pcs[0] !== 32'h0 || pcs[1] !== 32'h4 || pcs[2] !== 32'h8) begin
            failures++;
            $display("FAIL basic_pcs got_n=%0d exp=0,4,8", pcs.size());
        end
        checks++;
        if (pat !== 6'b010101) begin
            failures++;
            $display("FAIL basic_pattern got=%b exp=010101", pat);
        end
    endtask

    task automatic test_stall();
        int n_grant = 0;
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (last_grant) n_grant++;
            checks++;
            if (instr_valid !== 1'b1 || pc_o !== 32'h8 || instr_o !== mem_word(32'h8)) begin
                failures++;
                $display("FAIL stall_frozen got=%b/%h/%h exp=1/8/%h", instr_valid, pc_o, instr_o, mem_word(32'h8));
            end
        end
        checks++;
        if (skid_full !== 1'b1 || n_grant != 1) begin
            failures++;
            $display("FAIL stall_skid got=%b/%0d exp=1/1", skid_full, n_grant);
        end
        stall = 1'b0;
        cycle();
        checks++;
        if (instr_valid !== 1'b1 || pc_o !== 32'hC) begin
            failures++;
            $display("FAIL release_c got=%b/%h exp=1/c", instr_valid, pc_o);
        end
        run_until_valid(10);
        checks++;
        if (pc_o !== 32'h10) begin
            failures++;
            $display("FAIL release_10 got=%h exp=10", pc_o);
        end
    endtask

    task automatic test_redirect_wait();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        k_min = 3; k_max = 3;
        run_until_grant(32'h10, 1'b0, 60);
        redirect = 1'b1; redirect_pc = 32'h100;
        cycle();
        redirect = 1'b0;
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_wait_flush got=%b exp=0", instr_valid);
        end
        run_until_grant(32'h100, 1'b1, 10);
        checks++;
        if (last_grant_addr !== 32'h100) begin
            failures++;
            $display("FAIL redir_wait_addr got=%h exp=100", last_grant_addr);
        end
        run_until_valid(10);
        checks++;
        if (pc_o !== 32'h100) begin
            failures++;
            $display("FAIL redir_wait_pc got=%h exp=100", pc_o);
        end
    endtask

    task automatic test_redirect_rvalid_gnt();
        k_min = 1; k_max = 1;
        run_until_grant(32'h104, 1'b0, 10);
        redirect = 1'b1; redirect_pc = 32'h200;
        cycle();
        redirect = 1'b0;
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_rvalid_flush got=%b exp=0", instr_valid);
        end
        run_until_valid(10);
        checks++;
        if (pc_o !== 32'h200) begin
            failures++;
            $display("FAIL redir_rvalid_pc got=%h exp=200", pc_o);
        end
        redirect = 1'b1; redirect_pc = 32'h200;
        cycle();
        redirect = 1'b0;
        checks++;
        if (last_grant !== 1'b1 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_gnt_cycle got=%b/%b exp=1/0", last_grant, instr_valid);
        end
        run_until_valid(12);
        checks++;
        if (pc_o !== 32'h200) begin
            failures++;
            $display("FAIL redir_gnt_pc got=%h exp=200", pc_o);
        end
    endtask

    task automatic test_redirect_stall_skid();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        checks++;
        if (skid_full !== 1'b1) begin
            failures++;
            $display("FAIL rs_skid_fill got=%b exp=1", skid_full);
        end
        redirect = 1'b1; redirect_pc = 32'h303;
        cycle();
        redirect = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || skid_full !== 1'b0) begin
            failures++;
            $display("FAIL rs_flush got=%b/%b exp=0/0", instr_valid, skid_full);
        end
        stall = 1'b0;
        run_until_valid(10);
        checks++;
        if (pc_o !== 32'h300) begin
            failures++;
            $display("FAIL rs_restart got=%h exp=300", pc_o);
        end
    endtask

    task automatic test_wrap_and_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect = 1'b0;
        run_until_valid(12);
        checks++;
        if (pc_o !== 32'hFFFF_FFFC || pcplus4_o !== 32'h0) begin
            failures++;
            $display("FAIL wrap_pc got=%h/%h exp=fffffffc/0", pc_o, pcplus4_o);
        end
        run_until_grant(32'h0, 1'b1, 10);
        checks++;
        if (last_grant_addr !== 32'h0) begin
            failures++;
            $display("FAIL wrap_addr got=%h exp=0", last_grant_addr);
        end
        k_min = 4; k_max = 4;
        run_until_valid(12);
        run_until_grant(32'h0, 1'b1, 10);
        cycle();
        rst = 1'b1;
        cycle();
        check_reset_values("mid_reset");
        rst = 1'b0;
        run_until_grant(32'h0, 1'b1, 3);
        checks++;
        if (last_grant_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_pc_addr got=%h exp=0", last_grant_addr);
        end
    endtask

    task automatic test_random();
        k_min = 1; k_max = 4; gnt_pct = 60;
        for (int i = 0; i < 3000; i++) begin
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            rst         = ($urandom_range(0, 499) == 0);
            cycle();
        end
        rst = 1'b0; stall = 1'b0; redirect = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid_gnt();
        test_redirect_stall_skid();
        test_wrap_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
